wide_add_seq: RTL and testbench

- Multi-cycle sequencer that adds two wide operands of W = N*K bits.
- Reuses one N-bit library adder (ADD, with carry-in) word by word, one word per cycle, least-significant word first.
- Carry is held in a register between words.
- Produces a (W+1)-bit result whose top bit follows the existing conventions: unsigned gives the carry-out; signed gives a sign-correct extension.
- Sits in front of wide accumulators, where one narrow adder is shared instead of building a W-bit adder.

---
 rtl/wide_add_seq_pkg.sv | 22 ++
 rtl/wide_add_seq_add.sv | 29 ++
 rtl/wide_add_seq.sv | 108 ++++++++++
 tb/tb_wide_add_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/wide_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_seq_pkg
// Brief    : State encoding and index-width helper for the wide sequential adder
// Revision : 1.0 - initial release
// ============================================================================
package wide_add_seq_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // A single-word operand still needs a 1-bit index register.
    function automatic int idx_width(input int k);
        if (k <= 1) begin
            return 1;
        end
        return $clog2(k);
    endfunction

endpackage : wide_add_seq_pkg
`default_nettype wire

// File: rtl/wide_add_seq_add.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_seq_add
// Brief    : N-bit ripple-carry adder with carry-in, shared word datapath
// Revision : 1.0 - initial release
// ============================================================================
module wide_add_seq_add #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         CI,
    output logic [N-1:0] S,
    output logic         CO
);

    logic [N:0] w_c;

    assign w_c[0] = CI;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign S[i]     = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign CO = w_c[N];

endmodule : wide_add_seq_add
`default_nettype wire

// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_seq
// Brief    : Adds two N*K-bit operands one N-bit word per cycle, LSW first
// Revision : 1.0 - initial release
// ============================================================================
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [N*K-1:0] A,
    input  logic [N*K-1:0] B,
    output logic [N*K:0]   O,
    output logic           busy,
    output logic           done
);

    localparam int                c_W    = N * K;
    localparam int                c_IW   = idx_width(K);
    localparam logic [c_IW-1:0]   c_LAST = c_IW'(K - 1);

    logic [1:0]      r_state;
    logic [c_W-1:0]  r_a;
    logic [c_W-1:0]  r_b;
    logic            r_sgn;
    logic            r_carry;
    logic [c_IW-1:0] r_idx;

    logic [N-1:0]    w_a_word;
    logic [N-1:0]    w_b_word;
    logic [N-1:0]    w_sum;
    logic            w_co;
    logic            w_top;

    assign w_a_word = r_a[r_idx*N +: N];
    assign w_b_word = r_b[r_idx*N +: N];

    wide_add_seq_add #(
        .N (N)
    ) u_add (
        .A  (w_a_word),
        .B  (w_b_word),
        .CI (r_carry),
        .S  (w_sum),
        .CO (w_co)
    );

    // With differing operand signs the true sum cannot overflow, so the
    // extension bit simply copies the sign bit of the last word.
    assign w_top = (r_sgn && (r_a[c_W-1] ^ r_b[c_W-1])) ? w_sum[N-1] : w_co;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sgn   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            O       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_sgn   <= sgn;
                        r_carry <= 1'b0;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= c_ST_RUN;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_RUN: begin
                    O[r_idx*N +: N] <= w_sum;
                    r_carry         <= w_co;
                    if (r_idx == c_LAST) begin
                        O[c_W]  <= w_top;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule : wide_add_seq
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_wide_add_seq
// Brief    : Directed and reference-model checks of wide_add_seq (N=8,K=4 and N=32,K=1)
// Revision : 1.0 - initial release
// ============================================================================
module tb_wide_add_seq;

    localparam int N = 8;
    localparam int K = 4;

    logic        clk = 1'b0;
    logic        r_rst;
    logic        r_start;
    logic        r_sgn;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [32:0] w_o;
    logic        w_busy;
    logic        w_done;

    logic        r_start1;
    logic        r_sgn1;
    logic [31:0] r_a1;
    logic [31:0] r_b1;
    logic [32:0] w_o1;
    logic        w_busy1;
    logic        w_done1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wide_add_seq #(.N(N), .K(K)) u_dut (
        .clk   (clk),
        .rst   (r_rst),
        .start (r_start),
        .sgn   (r_sgn),
        .A     (r_a),
        .B     (r_b),
        .O     (w_o),
        .busy  (w_busy),
        .done  (w_done)
    );

    wide_add_seq #(.N(32), .K(1)) u_dut_k1 (
        .clk   (clk),
        .rst   (r_rst),
        .start (r_start1),
        .sgn   (r_sgn1),
        .A     (r_a1),
        .B     (r_b1),
        .O     (w_o1),
        .busy  (w_busy1),
        .done  (w_done1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Starts one addition, scrambles the inputs afterwards, checks result timing.
    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [32:0] exp, input bit full);
        @(negedge clk);
        r_sgn = s; r_a = a; r_b = b; r_start = 1'b1;
        @(negedge clk);
        r_start = 1'b0; r_a = $urandom; r_b = $urandom; r_sgn = ~s;
        if (full) begin
            for (int i = 0; i < K; i++) begin
                check_eq({tag, "_busy"}, {63'd0, w_busy & ~w_done}, 64'd1);
                if (i < K - 1) @(negedge clk);
            end
        end else begin
            repeat (K - 1) @(negedge clk);
        end
        @(negedge clk);
        if (full) begin
            check_eq({tag, "_done"}, {62'd0, w_done, w_busy}, 64'd2);
            check_eq({tag, "_O"}, {31'd0, w_o}, {31'd0, exp});
            @(negedge clk);
            check_eq({tag, "_pulse"}, {63'd0, w_done}, 64'd0);
        end else begin
            check_eq({tag, "_doneO"}, {30'd0, w_done, w_o}, {30'd0, 1'b1, exp});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic [32:0] rexp;
        bit          seen;

        r_rst = 1'b1; r_start = 1'b0; r_sgn = 1'b0; r_a = '0; r_b = '0;
        r_start1 = 1'b0; r_sgn1 = 1'b0; r_a1 = '0; r_b1 = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_state", {29'd0, w_busy, w_done, w_o}, 64'd0);
        check_eq("reset_state_k1", {29'd0, w_busy1, w_done1, w_o1}, 64'd0);
        r_rst = 1'b0;

        run_op("ucarry",   1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000, 1'b1);
        run_op("sovf_pos", 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 33'h0_8000_0000, 1'b1);
        run_op("sovf_neg", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33'h1_7FFF_FFFF, 1'b1);
        run_op("smix",     1'b1, 32'hFFFF_FFFF, 32'h0000_0005, 33'h0_0000_0004, 1'b1);
        run_op("sneg",     1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, 1'b1);
        run_op("uplain",   1'b0, 32'h1234_5678, 32'h0FED_CBA8, 33'h0_2222_2220, 1'b1);

        // start during RUN must be ignored; start during DONE is accepted
        @(negedge clk);
        r_sgn = 1'b0; r_a = 32'd1; r_b = 32'd2; r_start = 1'b1;
        @(negedge clk);
        r_start = 1'b0;
        @(negedge clk);
        r_start = 1'b1; r_a = 32'hAAAA_AAAA; r_b = 32'hAAAA_AAAA;
        @(negedge clk);
        r_start = 1'b0;
        @(negedge clk);
        check_eq("ign_nodone", {63'd0, w_done}, 64'd0);
        @(negedge clk);
        check_eq("ign_done", {63'd0, w_done}, 64'd1);
        check_eq("ign_O", {31'd0, w_o}, 64'd3);
        r_start = 1'b1; r_a = 32'd5; r_b = 32'd6;
        @(negedge clk);
        r_start = 1'b0;
        check_eq("b2b_busy", {62'd0, w_busy, w_done}, 64'd2);
        repeat (3) @(negedge clk);
        @(negedge clk);
        check_eq("b2b_done", {62'd0, w_done, w_busy}, 64'd2);
        check_eq("b2b_O", {31'd0, w_o}, 64'd11);

        // reset in the middle of a run
        @(negedge clk);
        r_sgn = 1'b0; r_a = 32'h0101_0101; r_b = 32'h0202_0202; r_start = 1'b1;
        @(negedge clk);
        r_start = 1'b0;
        @(negedge clk);
        r_rst = 1'b1;
        @(negedge clk);
        r_rst = 1'b0;
        check_eq("rst_mid", {29'd0, w_busy, w_done, w_o}, 64'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (w_done) seen = 1'b1;
        end
        check_eq("rst_nodone", {63'd0, seen}, 64'd0);
        run_op("after_rst", 1'b0, 32'h0101_0101, 32'h0202_0202, 33'h0_0303_0303, 1'b1);

        // K = 1, N = 32 instance
        @(negedge clk);
        r_sgn1 = 1'b0; r_a1 = 32'hFFFF_FFFF; r_b1 = 32'hFFFF_FFFF; r_start1 = 1'b1;
        @(negedge clk);
        r_start1 = 1'b0; r_a1 = '0; r_b1 = '0;
        check_eq("k1_busy", {62'd0, w_busy1, w_done1}, 64'd2);
        @(negedge clk);
        check_eq("k1_done", {62'd0, w_done1, w_busy1}, 64'd2);
        check_eq("k1_O", {31'd0, w_o1}, {31'd0, 33'h1_FFFF_FFFE});

        // random operations against a sign/zero-extended reference sum
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = n[0];
            if (rs) rexp = {ra[31], ra} + {rb[31], rb};
            else    rexp = {1'b0, ra} + {1'b0, rb};
            run_op("rand", rs, ra, rb, rexp, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wide_add_seq
`default_nettype wire
